mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one N-input data multiplexer between `N_REQ` requesters and drives a single registered output channel. Each requester offers a word with a valid/ready handshake. The arbiter picks one per cycle, steers the shared mux select to it, and captures the selected word into a one-entry output register. It sits between independent producers and a single downstream consumer, for example an LED/display driver or a serializer.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥ 2; need not be a power of 2.
- `W`, 8: data width per requester.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `N_REQ`: bit i set means requester i offers `req_data` slice i.
- `req_data` input `N_REQ*W`: requester i occupies bits [i*W +: W].
- `req_ready` output `N_REQ`: one-hot or zero. Bit i set means requester i's word is accepted this cycle.
- `out_valid` output 1: the output register holds a word.
- `out_data` output `W`: the registered word.
- `out_src` output `$clog2(N_REQ)`: index of the requester that supplied `out_data`.
- `out_ready` input 1: the consumer accepts the output word this cycle.

## Operation
- Internal state: the output register (`out_valid`, `out_data`, `out_src`) and the priority pointer `ptr`, range 0..N_REQ-1.
- The output register has two states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- `load = !out_valid || out_ready`. The register can take a new word this cycle.
- Grant selection: `g` is the first index with `req_valid` set, scanning `ptr`, `ptr+1`, … and wrapping mod `N_REQ`.
- When `load` and any `req_valid` is set:
  - `req_ready[g]` = 1 and all other bits are 0.
  - Next edge: `out_data` ← slice g, `out_src` ← g, `out_valid` ← 1, `ptr` ← (g+1) mod `N_REQ`.
  - Wrap is explicit: g = N_REQ-1 gives `ptr` = 0, including for non-power-of-2 `N_REQ`.
- When `load` and no `req_valid` is set: `req_ready` = 0, next `out_valid` ← 0, `ptr` unchanged, `out_data`/`out_src` hold their values.
- When `!load` (FULL and `out_ready` = 0): `req_ready` = 0 and all state holds. The output is stable under backpressure.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on `out_ready` with a grant (back-to-back).
  - FULL→EMPTY on `out_ready` with no request.
  - FULL holds while `out_ready` = 0.
- Fairness: a requester held valid is granted within `N_REQ` output transfers.
- Requester i may drop `req_valid` before being granted. No word is lost or duplicated.
- `req_ready` is a combinational function of `req_valid`, `ptr`, `out_valid` and `out_ready`. There is no combinational path from `req_data` to any output.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_src` = 0, `ptr` = 0. `req_ready` = 0 in every cycle where `rst` = 1.
- Latency: a word accepted in cycle t (its `req_ready` bit high) appears on `out_data` with `out_valid` = 1 in cycle t+1.
- Throughput: one word per cycle while `out_ready` = 1 and requests are present.
- Simultaneous consume and refill: in a cycle with `out_valid` = 1 and `out_ready` = 1, the current word leaves and the next granted word loads at the same edge. There is no bubble.
- Reset mid-operation: a word held in the output register is discarded. Any `req_ready` pulse in the reset cycle is suppressed, so nothing is accepted. The first post-reset grant starts from index 0.

## Structure
- Shared package `mux_arb_pkg`:
  - default `N_REQ`, `W` constants.
  - `src_idx_t` typedef, `logic [$clog2(N_REQ)-1:0]`.
  - a `next_idx(idx)` wrap function used for the `ptr` update.
- One sub-module, `rr_pick`: a combinational round-robin priority picker. Inputs are `req_valid` and `ptr`. Outputs are a one-hot grant plus encoded index `g` and an `any` flag.
- The data steering in the top level is the shared mux (indexed slice by `g`).
- The top level holds only the output register and the pointer.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `req_valid` = 4'b1111 → `req_ready` = 0 throughout; `out_valid`/`out_data`/`out_src` = 0 after the first edge.
- Single requester: `req_valid` = 4'b0100, slice 2 = 8'hA5, `out_ready` = 1 → `req_ready` = 4'b0100 in cycle t; at t+1, `out_valid` = 1, `out_data` = 8'hA5, `out_src` = 2, `ptr` = 3.
- Full contention: all four valid (data 8'h10, 8'h11, 8'h12, 8'h13), `out_ready` = 1 → `out_src` sequence 0,1,2,3,0,1 with matching data, one word per cycle.
- Backpressure: `out_valid` = 1 with `out_src` = 1, `out_ready` = 0 for 3 cycles, all valid → `req_ready` = 0 and `out_data` stable. On release, next `out_src` = 2.
- Non-power-of-2 wrap: `N_REQ` = 3, all valid, `out_ready` = 1 → `out_src` 0,1,2,0,1; `ptr` never reaches 3.
- Reset mid-operation: FULL with `out_src` = 2, assert `rst` for 1 cycle → `out_valid` = 0. With all valid afterwards, the first grant is index 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the round-robin multiplexer arbiter:
//   N_REQ_DEF / W_DEF : default requester count and data width
//   src_idx_t         : requester index type for the default configuration
//   next_idx()        : round-robin successor of an index, wrapping at n
package mux_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 8;

   typedef logic [$clog2(N_REQ_DEF)-1:0] src_idx_t;

   // Successor with an explicit wrap, so non-power-of-2 counts never reach n.
   function automatic int unsigned next_idx(input int unsigned idx,
                                            input int unsigned n = N_REQ_DEF);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin priority picker.
// Ports:
//   req_valid : request vector, one bit per requester
//   ptr       : highest-priority index for this cycle (0..N_REQ-1)
//   grant     : one-hot grant, zero when no request is present
//   g         : encoded index of the granted requester (0 when none)
//   any       : at least one request is present
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] g,
   output logic                     any
);

   localparam int IW = $clog2(N_REQ);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   // Scan ptr, ptr+1, ... and keep the first hit. One extra bit on the sum
   // lets the wrap subtract work for counts that are not a power of 2.
   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise the
      // paths where no requester matches would infer latches.
      grant = '0;
      g     = '0;
      any   = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_REQ)) begin
            sum = sum - (IW+1)'(N_REQ);
         end
         idx = sum[IW-1:0];
         if (!any && req_valid[idx]) begin
            any        = 1'b1;
            g          = idx;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter sharing one data mux between N_REQ requesters and
// feeding a single one-entry registered output channel.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-requester offer
//   req_data   : packed request words, requester i at [i*W +: W]
//   req_ready  : one-hot accept strobe (zero when nothing is accepted)
//   out_valid  : output register holds a word
//   out_data   : registered word
//   out_src    : requester that supplied out_data
//   out_ready  : consumer takes the output word this cycle
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*W-1:0]       req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     out_valid,
   output logic [W-1:0]             out_data,
   output logic [$clog2(N_REQ)-1:0] out_src,
   input  logic                     out_ready
);

   localparam int IW = $clog2(N_REQ);

   logic [IW-1:0]    ptr;
   logic [IW-1:0]    g;
   logic [N_REQ-1:0] grant;
   logic             any;
   logic             load;
   logic [W-1:0]     sel_data;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .g         (g),
      .any       (any)
   );

   // The register can take a word when empty or when its word leaves now.
   assign load = !out_valid || out_ready;

   // Reset gates the strobe so no requester believes its word was taken.
   assign req_ready = (load && !rst) ? grant : '0;

   // Shared data mux steered by the grant index.
   assign sel_data = req_data[g*W +: W];

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register update in step
      // with the others on the same edge, independent of statement order.
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (any) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= g;
            ptr       <= IW'(next_idx(32'(g), N_REQ));
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Drives a 4-requester and a 3-requester arbiter from one clock and compares
// both against an integer-level round-robin model every cycle.
module tb_mux_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;

   logic [3:0]  valid4;
   logic [31:0] data4;
   logic        ordy4;
   logic [3:0]  rdy4;
   logic        ov4;
   logic [7:0]  od4;
   logic [1:0]  os4;

   logic [2:0]  valid3;
   logic [23:0] data3;
   logic        ordy3;
   logic [2:0]  rdy3;
   logic        ov3;
   logic [7:0]  od3;
   logic [1:0]  os3;

   int total = 0;
   int bad   = 0;

   // Model state per instance: [0] is N_REQ=4, [1] is N_REQ=3.
   bit mv[2];
   int md[2];
   int ms[2];
   int mp[2];
   int nreq[2] = '{4, 3};

   always #5 clk = ~clk;

   mux_rr_arbiter #(.N_REQ(4), .W(8)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (valid4),
      .req_data  (data4),
      .req_ready (rdy4),
      .out_valid (ov4),
      .out_data  (od4),
      .out_src   (os4),
      .out_ready (ordy4)
   );

   mux_rr_arbiter #(.N_REQ(3), .W(8)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (valid3),
      .req_data  (data3),
      .req_ready (rdy3),
      .out_valid (ov3),
      .out_data  (od3),
      .out_src   (os3),
      .out_ready (ordy3)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // First requester at or after p (mod n) with its valid bit set.
   function automatic void pick(input int n, input int p, input logic [3:0] v,
                                output int g, output bit found);
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < n; k++) begin
         int idx;
         idx = (p + k) % n;
         if (!found && (((v >> idx) & 4'd1) != 4'd0)) begin
            found = 1'b1;
            g     = idx;
         end
      end
   endfunction

   // One clock: check req_ready before the edge, advance the model at the
   // edge, check the registered outputs just after it.
   task automatic cycle();
      logic [3:0]  v[2];
      logic [31:0] d[2];
      bit          o[2];
      int          g[2];
      bit          found[2];
      bit          load[2];
      logic [31:0] exp_rdy;

      @(negedge clk);
      v[0] = valid4;
      v[1] = {1'b0, valid3};
      d[0] = data4;
      d[1] = {8'h00, data3};
      o[0] = ordy4;
      o[1] = ordy3;
      for (int i = 0; i < 2; i++) begin
         pick(nreq[i], mp[i], v[i], g[i], found[i]);
         load[i] = !mv[i] || o[i];
         exp_rdy = (!rst && load[i] && found[i]) ? (32'd1 << g[i]) : 32'd0;
         if (i == 0) check("req_ready4", 32'(rdy4), exp_rdy);
         else        check("req_ready3", 32'(rdy3), exp_rdy);
      end

      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mv[i] = 1'b0;
            md[i] = 0;
            ms[i] = 0;
            mp[i] = 0;
         end else if (load[i]) begin
            if (found[i]) begin
               mv[i] = 1'b1;
               md[i] = int'((d[i] >> (g[i] * 8)) & 32'hFF);
               ms[i] = g[i];
               mp[i] = (g[i] + 1) % nreq[i];
            end else begin
               mv[i] = 1'b0;
            end
         end
      end

      #1;
      check("out_valid4", 32'(ov4), 32'(mv[0]));
      check("out_data4",  32'(od4), 32'(md[0]));
      check("out_src4",   32'(os4), 32'(ms[0]));
      check("ptr4",       32'(dut4.ptr), 32'(mp[0]));
      check("out_valid3", 32'(ov3), 32'(mv[1]));
      check("out_data3",  32'(od3), 32'(md[1]));
      check("out_src3",   32'(os3), 32'(ms[1]));
      check("ptr3",       32'(dut3.ptr), 32'(mp[1]));
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         mv[i] = 1'b0;
         md[i] = 0;
         ms[i] = 0;
         mp[i] = 0;
      end

      // Reset for two cycles with every requester asking.
      rst    = 1'b1;
      valid4 = 4'b1111;
      data4  = $urandom;
      ordy4  = 1'b1;
      valid3 = 3'b111;
      data3  = 24'($urandom);
      ordy3  = 1'b1;
      repeat (2) cycle();
      check("rst_out_valid4", 32'(ov4), 32'd0);
      check("rst_out_data4",  32'(od4), 32'd0);

      // Single requester 2 with 8'hA5.
      rst    = 1'b0;
      valid4 = 4'b0100;
      data4  = 32'h00A5_0000;
      valid3 = 3'b000;
      cycle();
      check("single_data", 32'(od4), 32'h0000_00A5);
      check("single_src",  32'(os4), 32'd2);
      check("single_ptr",  32'(dut4.ptr), 32'd3);

      // Full contention from a fresh pointer; N_REQ=3 wraps alongside.
      rst = 1'b1;
      cycle();
      rst    = 1'b0;
      valid4 = 4'b1111;
      data4  = 32'h1312_1110;
      valid3 = 3'b111;
      data3  = 24'h22_21_20;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("contend_src4", 32'(os4), 32'(i % 4));
         if (i < 5) check("contend_src3", 32'(os3), 32'(i % 3));
      end

      // Backpressure with out_src = 1 held, then release.
      ordy4 = 1'b0;
      repeat (3) begin
         cycle();
         check("bp_data", 32'(od4), 32'h11);
      end
      ordy4 = 1'b1;
      cycle();
      check("bp_release_src", 32'(os4), 32'd2);

      // Reset mid-operation while FULL with out_src = 2.
      rst = 1'b1;
      cycle();
      check("midrst_valid", 32'(ov4), 32'd0);
      rst = 1'b0;
      cycle();
      check("midrst_first", 32'(os4), 32'd0);

      // Randomized traffic, drops, backpressure and occasional reset.
      for (int c = 0; c < 500; c++) begin
         rst    = ($urandom_range(0, 59) == 0);
         valid4 = 4'($urandom);
         data4  = $urandom;
         ordy4  = ($urandom_range(0, 3) != 0);
         valid3 = 3'($urandom);
         data3  = 24'($urandom);
         ordy3  = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
